ghash_ctrl: RTL

//  Sequencer for the bit-serial GF(2^128) multiplier in the AES-GCM GHASH path.
//  - Accepts 128-bit AAD/ciphertext blocks over a valid/ready handshake.
//  - Computes Y_i = (Y_{i-1} ^ X_i) * H, one multiplier operation per block.
//  - Presents the final Y as oTag. The multiplier is a separate instance driven through the oMul_*/iMul_* ports.

---
 rtl/ghash_pkg.sv | 18 +
 rtl/ghash_tmo_cnt.sv | 34 +++
 rtl/ghash_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ghash_pkg.sv
// Shared types and constants for the GHASH sequencer (ghash_ctrl).
// Optional length-block stage is enabled by defining GHASH_LEN_BLOCK_EN.
package ghash_pkg;
  localparam int         BLK_W           = 128;
  localparam logic [7:0] GCM_R           = 8'hE1;
  localparam int         MUL_TIMEOUT_DEF = 255;
  localparam int         TMO_W           = $clog2(MUL_TIMEOUT_DEF + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_START,
    S_ARM,
    S_WAIT,
    S_LEN,
    S_DONE
  } state_t;
endpackage

// File: rtl/ghash_tmo_cnt.sv
// Multiplier wait watchdog: counts cycles spent waiting and emits a one-cycle
// error pulse when the multiplier fails to answer within MUL_TIMEOUT cycles.
module ghash_tmo_cnt
  import ghash_pkg::*;
#(
  parameter int MUL_TIMEOUT = MUL_TIMEOUT_DEF,
  parameter int CNT_W       = TMO_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_done,
  output logic o_expire,
  output logic o_error
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MUL_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Expiry fires on the MUL_TIMEOUT-th wait cycle unless the product arrives then.
  assign o_expire = i_en && !i_done && (r_cnt == LIM);
  assign o_error  = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (i_en && !o_expire) ? r_cnt + 1'b1 : '0;
      r_err <= o_expire;
    end
  end
endmodule

// File: rtl/ghash_ctrl.sv
// GHASH sequencer driving an external bit-serial GF(2^128) multiplier:
// Y_i = (Y_{i-1} ^ X_i) * H. Define GHASH_LEN_BLOCK_EN to append the length block internally.
module ghash_ctrl
  import ghash_pkg::*;
#(
  parameter int LEN_W       = 64,
  parameter int MUL_TIMEOUT = MUL_TIMEOUT_DEF
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [BLK_W-1:0] iHashkey,
  input  logic [LEN_W-1:0] iLen_aad,
  input  logic [LEN_W-1:0] iLen_ct,
  input  logic [BLK_W-1:0] iData,
  input  logic             iData_valid,
  input  logic             iData_last,
  output logic             oData_ready,
  output logic             oMul_next,
  output logic             oMul_valid,
  output logic [BLK_W-1:0] oMul_x,
  output logic [BLK_W-1:0] oMul_h,
  input  logic [BLK_W-1:0] iMul_result,
  input  logic             iMul_done,
  output logic [BLK_W-1:0] oTag,
  output logic             oTag_valid,
  output logic             oBusy,
  output logic             oError
);
  localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_next;
  logic [BLK_W-1:0] r_y;
  logic [BLK_W-1:0] r_h;
  logic [BLK_W-1:0] r_mul_x;
  logic             r_last;
  logic             w_expire;

`ifdef GHASH_LEN_BLOCK_EN
  logic [2*LEN_W-1:0] r_len;
  logic               r_lenop;
`else
  logic               w_unused_len;
  assign w_unused_len = ^{iLen_aad, iLen_ct};
`endif

  ghash_tmo_cnt #(
    .MUL_TIMEOUT (MUL_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_tmo (
    .i_clk    (iClk),
    .i_rst    (iRst),
    .i_en     (r_state == S_WAIT),
    .i_done   (iMul_done),
    .o_expire (w_expire),
    .o_error  (oError)
  );

  assign oMul_x = r_mul_x;
  assign oMul_h = r_h;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= S_IDLE;
      r_y     <= '0;
      r_h     <= '0;
      r_mul_x <= '0;
      r_last  <= 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
      r_len   <= '0;
      r_lenop <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            r_h <= iHashkey;
            r_y <= '0;
`ifdef GHASH_LEN_BLOCK_EN
            r_len   <= {iLen_aad, iLen_ct};
            r_lenop <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (iData_valid) begin
            r_mul_x <= r_y ^ iData;
            r_last  <= iData_last;
          end
        end
        S_WAIT: begin
          // A timed-out hash must not leak a partial Y into the next one.
          if (iMul_done)     r_y <= iMul_result;
          else if (w_expire) r_y <= '0;
        end
`ifdef GHASH_LEN_BLOCK_EN
        S_LEN: begin
          r_mul_x <= r_y ^ r_len;
          r_lenop <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    oData_ready = 1'b0;
    oMul_next   = 1'b0;
    oMul_valid  = 1'b0;
    oTag        = '0;
    oTag_valid  = 1'b0;
    oBusy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        oBusy = 1'b0;
        if (iStart) w_next = S_RUN;
      end
      S_RUN: begin
        oData_ready = 1'b1;
        if (iData_valid) w_next = S_START;
      end
      S_START: begin
        oMul_next  = 1'b1;
        oMul_valid = 1'b1;
        w_next     = S_ARM;
      end
      // done may still be high from the previous product here, so it is not looked at.
      S_ARM: begin
        oMul_valid = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        oMul_valid = 1'b1;
        if (iMul_done) begin
`ifdef GHASH_LEN_BLOCK_EN
          if (r_lenop)     w_next = S_DONE;
          else if (r_last) w_next = S_LEN;
          else             w_next = S_RUN;
`else
          w_next = r_last ? S_DONE : S_RUN;
`endif
        end else if (w_expire) begin
          w_next = S_IDLE;
        end
      end
      S_LEN: w_next = S_START;
      S_DONE: begin
        oBusy      = 1'b0;
        oTag       = r_y;
        oTag_valid = 1'b1;
        if (iStart) w_next = S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
